tennis_set_scorer: RTL and testbench

Parametrised tennis scoring engine: tracks points within a game, including deuce and advantage, and games within a set for two players. Point-win pulses come from the umpire input logic. Score, status and game counts go to the display/scoreboard logic. This block supersedes the fixed deuce-only FSM. Win threshold, win margin and set length are generic, and it adds full point counting, game counting and set completion.

---
 rtl/tennis_set_scorer.sv | 126 ++++++++++++
 tb/tb_tennis_set_scorer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tennis_set_scorer.sv
// Two-player tennis scorer: points within a game (with deuce/advantage) and games within a set.
// Point counters are deuce-normalised so they stay bounded however long a game runs.
module tennis_set_scorer #(
  parameter int WIN_PTS      = 4,
  parameter int MARGIN       = 2,
  parameter int PT_W         = 3,
  parameter int GAMES_TO_SET = 6,
  parameter int GW           = 5
) (
  input  logic            clk,
  input  logic            rs,
  input  logic            p1,
  input  logic            p2,
  output logic [PT_W-1:0] pts1,
  output logic [PT_W-1:0] pts2,
  output logic [GW-1:0]   games1,
  output logic [GW-1:0]   games2,
  output logic [2:0]      Y
);

  typedef enum logic [2:0] {PLAY, GAME1, GAME2, SET1, SET2} state_t;

  // Point arithmetic runs one bit wider so the candidate count and lead sums never wrap.
  localparam logic [PT_W:0] ONE_P = (PT_W+1)'(1);
  localparam logic [PT_W:0] WIN_C = (PT_W+1)'(WIN_PTS);
  localparam logic [PT_W:0] WM1_C = (PT_W+1)'(WIN_PTS - 1);
  localparam logic [PT_W:0] MAR_C = (PT_W+1)'(MARGIN);
  localparam logic [GW:0]   GTS_C = (GW+1)'(GAMES_TO_SET);
  localparam logic [GW:0]   TWO_G = (GW+1)'(2);
  localparam logic [GW-1:0] ONE_G = GW'(1);
  localparam logic [GW-1:0] MAX_G = '1;

  state_t          state, state_nx;
  logic [PT_W-1:0] pts1_nx, pts2_nx;
  logic [GW-1:0]   games1_nx, games2_nx;

  logic [PT_W:0] w1, w2, c1, c2, t1, t2;
  logic [GW:0]   wg1, wg2;
  logic          pt1, pt2, win1, win2, set1, set2;

  assign w1  = {1'b0, pts1};
  assign w2  = {1'b0, pts2};
  assign wg1 = {1'b0, games1};
  assign wg2 = {1'b0, games2};
  assign c1  = w1 + ONE_P;
  assign c2  = w2 + ONE_P;

  assign pt1  = p1 & ~p2;
  assign pt2  = p2 & ~p1;
  assign win1 = (c1 >= WIN_C) && (c1 >= w2 + MAR_C);
  assign win2 = (c2 >= WIN_C) && (c2 >= w1 + MAR_C);
  assign set1 = (wg1 >= GTS_C) && (wg1 >= wg2 + TWO_G);
  assign set2 = (wg2 >= GTS_C) && (wg2 >= wg1 + TWO_G);

  always_ff @(posedge clk) begin
    if (rs) begin
      state  <= PLAY;
      pts1   <= '0;
      pts2   <= '0;
      games1 <= '0;
      games2 <= '0;
    end else begin
      state  <= state_nx;
      pts1   <= pts1_nx;
      pts2   <= pts2_nx;
      games1 <= games1_nx;
      games2 <= games2_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pts1_nx   = pts1;
    pts2_nx   = pts2;
    games1_nx = games1;
    games2_nx = games2;
    t1        = w1;
    t2        = w2;
    unique case (state)
      PLAY: begin
        if (pt1 && win1) begin
          state_nx  = GAME1;
          pts1_nx   = '0;
          pts2_nx   = '0;
          games1_nx = (games1 == MAX_G) ? games1 : games1 + ONE_G;
        end else if (pt2 && win2) begin
          state_nx  = GAME2;
          pts1_nx   = '0;
          pts2_nx   = '0;
          games2_nx = (games2 == MAX_G) ? games2 : games2 + ONE_G;
        end else if (pt1 || pt2) begin
          t1 = pt1 ? c1 : w1;
          t2 = pt2 ? c2 : w2;
          // Deuce normalisation: both at or past the threshold collapses back by one.
          if (t1 >= WIN_C && t2 >= WIN_C) begin
            t1 = t1 - ONE_P;
            t2 = t2 - ONE_P;
          end
          pts1_nx = t1[PT_W-1:0];
          pts2_nx = t2[PT_W-1:0];
        end
      end
      GAME1:   state_nx = set1 ? SET1 : PLAY;
      GAME2:   state_nx = set2 ? SET2 : PLAY;
      default: state_nx = state;
    endcase
  end

  always_comb begin
    Y = 3'b000;
    unique case (state)
      PLAY: begin
        if (w1 >= WM1_C && w2 >= WM1_C) begin
          if (pts1 > pts2)      Y = 3'b001;
          else if (pts2 > pts1) Y = 3'b010;
        end
      end
      GAME1:   Y = 3'b011;
      GAME2:   Y = 3'b100;
      SET1:    Y = 3'b101;
      SET2:    Y = 3'b110;
      default: Y = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_tennis_set_scorer.sv
// Directed bench for tennis_set_scorer: vector table for point play, hand sequences for
// set completion, resets and a short-game parameter variant.
module tb_tennis_set_scorer;

  localparam logic [2:0] Y_PLAY = 3'b000, Y_ADV1 = 3'b001, Y_ADV2 = 3'b010,
                         Y_G1 = 3'b011, Y_G2 = 3'b100, Y_S1 = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rs, p1, p2;
  logic [2:0] pts1, pts2, y;
  logic [4:0] games1, games2;

  logic       rs_v, p1_v, p2_v;
  logic [2:0] pts1_v, pts2_v, y_v;
  logic [4:0] games1_v, games2_v;

  int checks = 0;
  int errors = 0;

  tennis_set_scorer u_dut (
    .clk(clk), .rs(rs), .p1(p1), .p2(p2),
    .pts1(pts1), .pts2(pts2), .games1(games1), .games2(games2), .Y(y)
  );

  tennis_set_scorer #(.WIN_PTS(2), .MARGIN(1), .PT_W(3), .GAMES_TO_SET(1), .GW(5)) u_var (
    .clk(clk), .rs(rs_v), .p1(p1_v), .p2(p2_v),
    .pts1(pts1_v), .pts2(pts2_v), .games1(games1_v), .games2(games2_v), .Y(y_v)
  );

  typedef struct {
    logic       rs, p1, p2;
    logic [2:0] e1, e2;
    logic [4:0] g1, g2;
    logic [2:0] ey;
  } vec_t;

  vec_t vt[25];

  task automatic cmp(input string nm,
                     input logic [2:0] a1, a2, input logic [4:0] ag1, ag2, input logic [2:0] ay,
                     input logic [2:0] e1, e2, input logic [4:0] eg1, eg2, input logic [2:0] ey);
    checks++;
    if (a1 !== e1 || a2 !== e2 || ag1 !== eg1 || ag2 !== eg2 || ay !== ey) begin
      errors++;
      $display("FAIL %s: got pts %0d/%0d games %0d/%0d Y=%b, want pts %0d/%0d games %0d/%0d Y=%b",
               nm, a1, a2, ag1, ag2, ay, e1, e2, eg1, eg2, ey);
    end
  endtask

  task automatic chk(input string nm, input logic [2:0] e1, e2, input logic [4:0] eg1, eg2,
                     input logic [2:0] ey);
    cmp(nm, pts1, pts2, games1, games2, y, e1, e2, eg1, eg2, ey);
  endtask

  task automatic chk_v(input string nm, input logic [2:0] e1, e2, input logic [4:0] eg1, eg2,
                       input logic [2:0] ey);
    cmp(nm, pts1_v, pts2_v, games1_v, games2_v, y_v, e1, e2, eg1, eg2, ey);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic drive(input logic r, input logic a, input logic b);
    @(negedge clk);
    rs = r; p1 = a; p2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_v(input logic r, input logic a, input logic b);
    @(negedge clk);
    rs_v = r; p1_v = a; p2_v = b;
    @(posedge clk);
    #1;
  endtask

  // Four straight points from 0/0 for player k, then the one-cycle GAME state passes idle.
  task automatic win_game(input int k, input logic [4:0] eg1, input logic [4:0] eg2);
    for (int i = 0; i < 4; i++) drive(1'b0, k == 1, k == 2);
    chk($sformatf("game_win_p%0d", k), 3'd0, 3'd0, eg1, eg2, (k == 1) ? Y_G1 : Y_G2);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rs = 1'b1; p1 = 1'b0; p2 = 1'b0;
    rs_v = 1'b1; p1_v = 1'b0; p2_v = 1'b0;

    //        rs p1 p2  pts1 pts2 g1 g2  Y
    vt[0]  = '{1, 0, 0, 0, 0, 0, 0, Y_PLAY};
    vt[1]  = '{0, 1, 0, 1, 0, 0, 0, Y_PLAY};
    vt[2]  = '{0, 1, 0, 2, 0, 0, 0, Y_PLAY};
    vt[3]  = '{0, 1, 0, 3, 0, 0, 0, Y_PLAY};
    vt[4]  = '{0, 1, 0, 0, 0, 1, 0, Y_G1};
    vt[5]  = '{0, 0, 0, 0, 0, 1, 0, Y_PLAY};
    vt[6]  = '{0, 0, 1, 0, 1, 1, 0, Y_PLAY};
    vt[7]  = '{0, 0, 1, 0, 2, 1, 0, Y_PLAY};
    vt[8]  = '{0, 0, 1, 0, 3, 1, 0, Y_PLAY};
    vt[9]  = '{0, 1, 0, 1, 3, 1, 0, Y_PLAY};
    vt[10] = '{0, 1, 0, 2, 3, 1, 0, Y_PLAY};
    vt[11] = '{0, 1, 0, 3, 3, 1, 0, Y_PLAY};
    vt[12] = '{0, 1, 0, 4, 3, 1, 0, Y_ADV1};
    vt[13] = '{0, 0, 1, 3, 3, 1, 0, Y_PLAY};
    vt[14] = '{0, 0, 1, 3, 4, 1, 0, Y_ADV2};
    vt[15] = '{0, 0, 1, 0, 0, 1, 1, Y_G2};
    vt[16] = '{0, 0, 1, 0, 0, 1, 1, Y_PLAY};
    vt[17] = '{0, 1, 0, 1, 0, 1, 1, Y_PLAY};
    vt[18] = '{0, 1, 0, 2, 0, 1, 1, Y_PLAY};
    vt[19] = '{0, 0, 1, 2, 1, 1, 1, Y_PLAY};
    vt[20] = '{0, 1, 1, 2, 1, 1, 1, Y_PLAY};
    vt[21] = '{0, 1, 1, 2, 1, 1, 1, Y_PLAY};
    vt[22] = '{0, 1, 1, 2, 1, 1, 1, Y_PLAY};
    vt[23] = '{0, 0, 0, 2, 1, 1, 1, Y_PLAY};
    vt[24] = '{0, 0, 0, 2, 1, 1, 1, Y_PLAY};

    drive_v(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      drive(vt[i].rs, vt[i].p1, vt[i].p2);
      chk($sformatf("vec%0d", i), vt[i].e1, vt[i].e2, vt[i].g1, vt[i].g2, vt[i].ey);
    end

    // Set completion needs a two-game lead: 6-5 keeps playing, 7-5 closes the set.
    drive(1'b1, 1'b0, 1'b0);
    for (int g = 1; g <= 5; g++) begin
      win_game(1, 5'(g), 5'(g - 1));
      win_game(2, 5'(g), 5'(g));
    end
    chk("five_all", 0, 0, 5, 5, Y_PLAY);
    win_game(1, 6, 5);
    chk("six_five_play", 0, 0, 6, 5, Y_PLAY);
    win_game(1, 7, 5);
    chk("set1", 0, 0, 7, 5, Y_S1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
    chk("set1_frozen", 0, 0, 7, 5, Y_S1);

    // Reset during advantage at games 3/2.
    drive(1'b1, 1'b0, 1'b0);
    win_game(1, 1, 0);
    win_game(2, 1, 1);
    win_game(1, 2, 1);
    win_game(2, 2, 2);
    win_game(1, 3, 2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b0);
    chk("adv_before_rs", 4, 3, 3, 2, Y_ADV1);
    drive(1'b1, 1'b1, 1'b0);
    chk("rs_mid_adv", 0, 0, 0, 0, Y_PLAY);

    // Reset during a GAME1 cycle.
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0);
    chk("game1_before_rs", 0, 0, 1, 0, Y_G1);
    drive(1'b1, 1'b1, 1'b0);
    chk("rs_mid_game", 0, 0, 0, 0, Y_PLAY);

    // Short-game variant: two points win a game, a set still needs a 2-game lead.
    drive_v(1'b0, 1'b1, 1'b0);
    chk_v("var_pt1", 1, 0, 0, 0, Y_PLAY);
    drive_v(1'b0, 1'b1, 1'b0);
    chk_v("var_game1", 0, 0, 1, 0, Y_G1);
    drive_v(1'b0, 1'b0, 1'b0);
    chk_v("var_no_set_1_0", 0, 0, 1, 0, Y_PLAY);
    drive_v(1'b0, 1'b1, 1'b0);
    drive_v(1'b0, 1'b1, 1'b0);
    chk_v("var_game1_again", 0, 0, 2, 0, Y_G1);
    drive_v(1'b0, 1'b0, 1'b0);
    chk_v("var_set1", 0, 0, 2, 0, Y_S1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
